// File: rtl/load_store_controller_if.sv
// Bundle of request/response and data-memory signals for the load/store controller.
// Handshake: a request transfers on a rising clk edge where req_valid and req_ready
// are both 1; the requester holds req_* stable while req_valid=1 and req_ready=0.
// resp_valid is a one-cycle completion pulse with no backpressure.
interface load_store_controller_if #(
  parameter int WORDSIZE = 64
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [2:0]          req_funct3;
  logic [WORDSIZE-1:0] req_addr;
  logic [WORDSIZE-1:0] req_wdata;
  logic                resp_valid;
  logic [WORDSIZE-1:0] resp_rdata;
  logic                resp_error;
  logic [WORDSIZE-1:0] mem_addr;
  logic [WORDSIZE-1:0] mem_data_input;
  logic                mem_write_en;
  logic [WORDSIZE-1:0] mem_data_output;

  // Pipeline/memory side: issues requests and supplies memory read data.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_addr, mem_data_input, mem_write_en,
    output mem_data_output
  );

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_addr, mem_data_input, mem_write_en,
    input  mem_data_output
  );
endinterface

// File: rtl/load_store_controller.sv
// RISC-V load/store controller: turns byte-addressed B/H/W/D loads and stores into
// doubleword-wide memory accesses. Sub-word stores use read-modify-write.
// All outputs except req_ready come straight from registers.
module load_store_controller #(
  parameter int WORDSIZE = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  load_store_controller_if.slave bus,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  logic                lat_write;
  logic [2:0]          lat_funct3;
  logic [2:0]          lat_off;
  logic [WORDSIZE-1:0] lat_wdata;

  logic                resp_valid_q;
  logic                resp_error_q;
  logic [WORDSIZE-1:0] resp_rdata_q;
  logic [WORDSIZE-1:0] mem_addr_q;
  logic [WORDSIZE-1:0] mem_data_input_q;
  logic                mem_write_en_q;

  // Illegal width code, sub-word unsigned stores, or misaligned access.
  function automatic logic req_is_error(input logic wr, input logic [2:0] f3,
                                        input logic [2:0] a);
    logic err;
    err = 1'b0;
    case (f3)
      3'b001, 3'b101: err = a[0];
      3'b010, 3'b110: err = |a[1:0];
      3'b011:         err = |a[2:0];
      3'b111:         err = 1'b1;
      default:        err = 1'b0;
    endcase
    if (wr && f3[2]) err = 1'b1;
    return err;
  endfunction

  // Pick the addressed lane (little-endian) and sign/zero extend.
  function automatic logic [WORDSIZE-1:0] load_extend(input logic [2:0] f3,
                                                      input logic [2:0] a,
                                                      input logic [WORDSIZE-1:0] dw);
    logic [WORDSIZE-1:0] sh;
    logic [WORDSIZE-1:0] res;
    sh = dw >> {a, 3'b000};
    case (f3)
      3'b000:  res = {{(WORDSIZE-8){sh[7]}}, sh[7:0]};
      3'b001:  res = {{(WORDSIZE-16){sh[15]}}, sh[15:0]};
      3'b010:  res = {{(WORDSIZE-32){sh[31]}}, sh[31:0]};
      3'b100:  res = {{(WORDSIZE-8){1'b0}}, sh[7:0]};
      3'b101:  res = {{(WORDSIZE-16){1'b0}}, sh[15:0]};
      3'b110:  res = {{(WORDSIZE-32){1'b0}}, sh[31:0]};
      default: res = dw;
    endcase
    return res;
  endfunction

  // Replace only the addressed byte lanes of the old doubleword.
  function automatic logic [WORDSIZE-1:0] store_merge(input logic [2:0] f3,
                                                      input logic [2:0] a,
                                                      input logic [WORDSIZE-1:0] old_dw,
                                                      input logic [WORDSIZE-1:0] wd);
    logic [WORDSIZE-1:0] mask;
    case (f3[1:0])
      2'b00:   mask = {{(WORDSIZE-8){1'b0}}, 8'hFF};
      2'b01:   mask = {{(WORDSIZE-16){1'b0}}, 16'hFFFF};
      default: mask = {{(WORDSIZE-32){1'b0}}, 32'hFFFF_FFFF};
    endcase
    mask = mask << {a, 3'b000};
    return (old_dw & ~mask) | ((wd << {a, 3'b000}) & mask);
  endfunction

  // Main controller FSM; every bus output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      lat_write        <= 1'b0;
      lat_funct3       <= 3'b000;
      lat_off          <= 3'b000;
      lat_wdata        <= '0;
      resp_valid_q     <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_rdata_q     <= '0;
      mem_addr_q       <= '0;
      mem_data_input_q <= '0;
      mem_write_en_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write  <= bus.req_write;
            lat_funct3 <= bus.req_funct3;
            lat_off    <= bus.req_addr[2:0];
            lat_wdata  <= bus.req_wdata;
            if (req_is_error(bus.req_write, bus.req_funct3, bus.req_addr[2:0])) begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= '0;
              state        <= RESP;
            end else begin
              mem_addr_q <= {bus.req_addr[WORDSIZE-1:3], 3'b000};
              if (bus.req_write && bus.req_funct3 == 3'b011) begin
                // Full doubleword store needs no read.
                mem_data_input_q <= bus.req_wdata;
                mem_write_en_q   <= 1'b1;
                state            <= WRITE;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          if (lat_write) begin
            mem_data_input_q <= store_merge(lat_funct3, lat_off, bus.mem_data_output, lat_wdata);
            mem_write_en_q   <= 1'b1;
            state            <= WRITE;
          end else begin
            resp_rdata_q <= load_extend(lat_funct3, lat_off, bus.mem_data_output);
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            state        <= RESP;
          end
        end
        WRITE: begin
          mem_write_en_q <= 1'b0;
          resp_valid_q   <= 1'b1;
          resp_error_q   <= 1'b0;
          resp_rdata_q   <= '0;
          state          <= RESP;
        end
        default: begin
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Ready only in IDLE and never while reset is asserted.
  assign bus.req_ready      = (state == IDLE) && rst_n;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_data_input = mem_data_input_q;
  assign bus.mem_write_en   = mem_write_en_q;
  assign dbg_state          = state;

endmodule

// File: tb/tb_load_store_controller.sv
// Directed bench for load_store_controller with a combinational 8-doubleword memory.
module tb_load_store_controller;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;

  int checks;
  int failures;
  int resp_cnt;
  int wr_count;
  logic [63:0] last_wr_addr;
  logic [63:0] last_wr_data;
  logic [63:0] mem [0:7];

  logic [63:0] exp_q[$];
  logic [63:0] err_q[$];

  load_store_controller_if #(.WORDSIZE(64)) bus();

  load_store_controller #(.WORDSIZE(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Memory model: combinational read, write on rising edge.
  assign bus.mem_data_output = mem[bus.mem_addr[5:3]];

  always @(posedge clk) begin
    if (bus.mem_write_en) begin
      mem[bus.mem_addr[5:3]] <= bus.mem_data_input;
      wr_count     = wr_count + 1;
      last_wr_addr = bus.mem_addr;
      last_wr_data = bus.mem_data_input;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every response is matched against the expected queue.
  always @(posedge clk) begin
    #1;
    if (bus.resp_valid) begin
      resp_cnt = resp_cnt + 1;
      if (exp_q.size() == 0) begin
        check_eq($sformatf("unexpected resp #%0d", resp_cnt), {63'd0, bus.resp_valid}, 64'd0);
      end else begin
        check_eq($sformatf("resp_rdata #%0d", resp_cnt), bus.resp_rdata, exp_q.pop_front());
        check_eq($sformatf("resp_error #%0d", resp_cnt), {63'd0, bus.resp_error}, err_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata);
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_wr);
    int lat;
    int wr0;
    @(negedge clk);
    check_eq({tag, " req_ready"}, {63'd0, bus.req_ready}, 64'd1);
    drive(wr, f3, addr, wdata);
    bus.req_valid = 1'b1;
    exp_q.push_back(exp_rdata);
    err_q.push_back({63'd0, exp_err});
    wr0 = wr_count;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    drive(1'b0, 3'b000, 64'd0, 64'd0);
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    check_eq({tag, " resp pulse end"}, {63'd0, bus.resp_valid}, 64'd0);
    check_eq({tag, " mem writes"}, 64'(wr_count - wr0), 64'(exp_wr));
  endtask

  initial begin
    int base;
    int wr0;
    int n;
    checks = 0;
    failures = 0;
    resp_cnt = 0;
    wr_count = 0;
    last_wr_addr = '0;
    last_wr_data = '0;
    rst_n = 1'b0;
    bus.req_valid = 1'b1;
    drive(1'b1, 3'b011, 64'h10, 64'hFFFF_0000_FFFF_0000);

    // Reset with a request presented: nothing accepted, outputs cleared.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst req_ready", {63'd0, bus.req_ready}, 64'd0);
    check_eq("rst state", {62'd0, dbg_state}, 64'd0);
    check_eq("rst resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    check_eq("rst resp_error", {63'd0, bus.resp_error}, 64'd0);
    check_eq("rst resp_rdata", bus.resp_rdata, 64'd0);
    check_eq("rst mem_addr", bus.mem_addr, 64'd0);
    check_eq("rst mem_data_input", bus.mem_data_input, 64'd0);
    check_eq("rst mem_we", {63'd0, bus.mem_write_en}, 64'd0);
    check_eq("rst writes", 64'(wr_count), 64'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_eq("post-rst req_ready", {63'd0, bus.req_ready}, 64'd1);

    // SD then LD of the same doubleword.
    do_req("sd 0x10", 1'b1, 3'b011, 64'h10, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 2, 1);
    check_eq("sd wr addr", last_wr_addr, 64'h10);
    check_eq("sd wr data", last_wr_data, 64'h1122_3344_5566_7788);
    do_req("ld 0x10", 1'b0, 3'b011, 64'h10, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 2, 0);

    // SB read-modify-write.
    do_req("sb 0x13", 1'b1, 3'b000, 64'h13, 64'h0000_0000_0000_00AB, 64'd0, 1'b0, 3, 1);
    check_eq("sb wr addr", last_wr_addr, 64'h10);
    check_eq("sb wr data", last_wr_data, 64'h1122_3344_AB66_7788);

    // Extension patterns.
    do_req("sd pattern", 1'b1, 3'b011, 64'h10, 64'h0000_0000_FFFF_8080, 64'd0, 1'b0, 2, 1);
    do_req("lb 0x10", 1'b0, 3'b000, 64'h10, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 0);
    do_req("lbu 0x10", 1'b0, 3'b100, 64'h10, 64'd0, 64'h80, 1'b0, 2, 0);
    do_req("lh 0x12", 1'b0, 3'b001, 64'h12, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2, 0);
    do_req("lwu 0x10", 1'b0, 3'b110, 64'h10, 64'd0, 64'hFFFF_8080, 1'b0, 2, 0);
    do_req("lw 0x10", 1'b0, 3'b010, 64'h10, 64'd0, 64'hFFFF_FFFF_FFFF_8080, 1'b0, 2, 0);
    do_req("lw 0x14", 1'b0, 3'b010, 64'h14, 64'd0, 64'd0, 1'b0, 2, 0);

    // Error cases: 1-cycle latency, no memory write.
    do_req("err lw 0x12", 1'b0, 3'b010, 64'h12, 64'd0, 64'd0, 1'b1, 1, 0);
    do_req("err store f3=100", 1'b1, 3'b100, 64'h10, 64'hFF, 64'd0, 1'b1, 1, 0);
    do_req("err f3=111", 1'b0, 3'b111, 64'h10, 64'd0, 64'd0, 1'b1, 1, 0);
    do_req("err ld 0x14", 1'b0, 3'b011, 64'h14, 64'd0, 64'd0, 1'b1, 1, 0);
    do_req("err sh 0x11", 1'b1, 3'b001, 64'h11, 64'h1234, 64'd0, 1'b1, 1, 0);
    do_req("err sd 0x14", 1'b1, 3'b011, 64'h14, 64'h1, 64'd0, 1'b1, 1, 0);

    // SH / SW merges, then read back lanes.
    do_req("sh 0x16", 1'b1, 3'b001, 64'h16, 64'h0000_0000_0000_BEEF, 64'd0, 1'b0, 3, 1);
    check_eq("sh wr data", last_wr_data, 64'hBEEF_0000_FFFF_8080);
    do_req("sw 0x10", 1'b1, 3'b010, 64'h10, 64'hDEAD_BEEF_1234_5678, 64'd0, 1'b0, 3, 1);
    check_eq("sw wr data", last_wr_data, 64'hBEEF_0000_1234_5678);
    do_req("ld merged", 1'b0, 3'b011, 64'h10, 64'd0, 64'hBEEF_0000_1234_5678, 1'b0, 2, 0);
    do_req("lh 0x16", 1'b0, 3'b001, 64'h16, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0, 2, 0);
    do_req("lhu 0x16", 1'b0, 3'b101, 64'h16, 64'd0, 64'hBEEF, 1'b0, 2, 0);
    do_req("lwu 0x14", 1'b0, 3'b110, 64'h14, 64'd0, 64'hBEEF_0000, 1'b0, 2, 0);
    do_req("lb 0x11", 1'b0, 3'b000, 64'h11, 64'd0, 64'h56, 1'b0, 2, 0);

    // Reset during WRITE of an SH: the in-flight write commits at that edge only.
    do_req("sd 0x18", 1'b1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0, 2, 1);
    base = resp_cnt;
    wr0 = wr_count;
    @(negedge clk);
    drive(1'b1, 3'b001, 64'h18, 64'h0000_0000_0000_AAAA);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (dbg_state != 2'd2 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("abort reached WRITE", {62'd0, dbg_state}, 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort mem_we after rst", {63'd0, bus.mem_write_en}, 64'd0);
    check_eq("abort state after rst", {62'd0, dbg_state}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("abort req_ready in rst", {63'd0, bus.req_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("abort req_ready after rst", {63'd0, bus.req_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort resp count", 64'(resp_cnt - base), 64'd0);
    check_eq("abort writes", 64'(wr_count - wr0), 64'd1);
    do_req("ld 0x18", 1'b0, 3'b011, 64'h18, 64'd0, 64'h0123_4567_89AB_AAAA, 1'b0, 2, 0);

    // req_valid held high with a new request while busy.
    base = resp_cnt;
    exp_q.push_back(64'hBEEF_0000_1234_5678);
    err_q.push_back(64'd0);
    exp_q.push_back(64'h56);
    err_q.push_back(64'd0);
    @(negedge clk);
    drive(1'b0, 3'b011, 64'h10, 64'd0);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 3'b100, 64'h11, 64'd0);
    check_eq("b2b first in READ", {62'd0, dbg_state}, 64'd1);
    @(posedge clk);
    #1;
    check_eq("b2b RESP", {62'd0, dbg_state}, 64'd3);
    @(posedge clk);
    #1;
    check_eq("b2b IDLE ready", {63'd0, bus.req_ready}, 64'd1);
    @(posedge clk);
    #1;
    check_eq("b2b second in READ", {62'd0, dbg_state}, 64'd1);
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("b2b resp count", 64'(resp_cnt - base), 64'd2);

    repeat (2) @(posedge clk);
    #1;
    check_eq("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
